// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - round-robin arbiter sharing one memory bus between iCache and dCache
module cache_mem_arbiter #(
    parameter int LINE_WORDS = 8,
    parameter int ADDR_W     = 32,
    parameter int CNT_W      = $clog2(LINE_WORDS) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_single,
    output logic              i_addr_ok,
    output logic              i_data_ok,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic              d_single,
    output logic              d_addr_ok,
    output logic              d_data_ok,
    output logic [31:0]       d_rdata,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [1:0]        mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [31:0]       mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

    state_t           state;
    logic             last_d;
    logic [CNT_W-1:0] target;
    logic [CNT_W-1:0] addr_cnt;
    logic [CNT_W-1:0] data_cnt;
    logic             addr_full;

    localparam logic [CNT_W-1:0] LINE_CNT = CNT_W'(LINE_WORDS);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    assign addr_full = (addr_cnt == target);

    // Bus side and master side are pure steering from the granted master.
    always_comb begin
        mem_req   = 1'b0;
        mem_wr    = 1'b0;
        mem_size  = 2'b00;
        mem_addr  = '0;
        mem_wdata = '0;
        i_addr_ok = 1'b0;
        i_data_ok = 1'b0;
        i_rdata   = '0;
        d_addr_ok = 1'b0;
        d_data_ok = 1'b0;
        d_rdata   = '0;
        busy      = 1'b0;
        case (state)
            GNT_I: begin
                busy      = 1'b1;
                mem_req   = i_req & ~addr_full;
                mem_size  = 2'b10;
                mem_addr  = i_addr;
                i_addr_ok = mem_addr_ok;
                i_data_ok = mem_data_ok;
                i_rdata   = mem_rdata;
            end
            GNT_D: begin
                busy      = 1'b1;
                mem_req   = d_req & ~addr_full;
                mem_wr    = d_wr;
                mem_size  = d_size;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
                d_addr_ok = mem_addr_ok;
                d_data_ok = mem_data_ok;
                d_rdata   = mem_rdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            last_d   <= 1'b0;
            target   <= '0;
            addr_cnt <= '0;
            data_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // On a tie the master that did not go last wins.
                    if (d_req && (!i_req || !last_d)) begin
                        state  <= GNT_D;
                        last_d <= 1'b1;
                        target <= d_single ? ONE_CNT : LINE_CNT;
                    end else if (i_req) begin
                        state  <= GNT_I;
                        last_d <= 1'b0;
                        target <= i_single ? ONE_CNT : LINE_CNT;
                    end
                end
                default: begin
                    if (mem_req && mem_addr_ok)
                        addr_cnt <= addr_cnt + ONE_CNT;
                    if (mem_data_ok) begin
                        if (data_cnt == target - ONE_CNT) begin
                            state    <= IDLE;
                            addr_cnt <= '0;
                            data_cnt <= '0;
                        end else begin
                            data_cnt <= data_cnt + ONE_CNT;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - table-driven and sequence checks for cache_mem_arbiter
module tb_cache_mem_arbiter;

    localparam logic [31:0] IA = 32'h1fc0_0000;
    localparam logic [31:0] DA = 32'h8000_1000;
    localparam logic [31:0] DW = 32'hdead_beef;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, i_single, i_addr_ok, i_data_ok;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_wr, d_single, d_addr_ok, d_data_ok;
    logic [1:0]  d_size;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        busy;

    int passed = 0;
    int total  = 0;
    logic [1:0] pipe;

    always #5 clk = ~clk;

    cache_mem_arbiter dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_single(i_single),
        .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_single(d_single),
        .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    typedef struct {
        logic        rst, ireq, isingle, dreq, dsingle, dwr, aok, dok;
        logic [31:0] rdata;
        logic [8:0]  flags;  // busy, mem_req, mem_wr, mem_size[1:0], i_aok, i_dok, d_aok, d_dok
        logic [31:0] irdata, drdata, maddr;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        i_req = 0; i_single = 0; d_req = 0; d_single = 0; d_wr = 0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
        pipe = 2'b00;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Memory that accepts one address per cycle and returns data two cycles later.
    task automatic model_cycle();
        @(negedge clk);
        mem_addr_ok = 1'b1;
        mem_data_ok = pipe[1];
        mem_rdata   = $urandom;
        #1;
        pipe = {pipe[0], mem_req & mem_addr_ok};
    endtask

    function automatic vec_t mk(input logic rst, ireq, isingle, dreq, dsingle, dwr, aok, dok,
                                input logic [31:0] rdata, input logic [8:0] flags,
                                input logic [31:0] irdata, drdata, maddr);
        vec_t v;
        v.rst = rst; v.ireq = ireq; v.isingle = isingle; v.dreq = dreq;
        v.dsingle = dsingle; v.dwr = dwr; v.aok = aok; v.dok = dok; v.rdata = rdata;
        v.flags = flags; v.irdata = irdata; v.drdata = drdata; v.maddr = maddr;
        return v;
    endfunction

    initial begin
        int acc, dcnt, ibad, wrbad, reqbad, rdbad, wdbad, c8, busy_next, ng, gapbad, idle, icnt;
        logic [3:0] gseq;
        logic prev_busy;

        reset = 1'b1;
        i_addr = IA; d_addr = DA; d_wdata = DW; d_size = 2'b01;
        i_req = 0; i_single = 0; d_req = 0; d_single = 0; d_wr = 0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0; pipe = 0;
        repeat (2) @(posedge clk);

        //            rst ir is dr ds dw ao do  rdata   flags            irdata  drdata  maddr
        vecs[0]  = mk(1, 1, 1, 0, 0, 0, 1, 1, 32'h11, 9'b0,            32'h0,  32'h0,  32'h0);
        vecs[1]  = mk(0, 1, 1, 0, 0, 0, 0, 0, 32'h0,  9'b0,            32'h0,  32'h0,  32'h0);
        vecs[2]  = mk(0, 1, 1, 0, 0, 0, 1, 0, 32'hAA, 9'b110_10_1000,  32'hAA, 32'h0,  IA);
        vecs[3]  = mk(0, 0, 1, 0, 0, 0, 0, 0, 32'h0,  9'b100_10_0000,  32'h0,  32'h0,  IA);
        vecs[4]  = mk(0, 0, 1, 0, 0, 0, 0, 1, 32'h55, 9'b100_10_0100,  32'h55, 32'h0,  IA);
        vecs[5]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h66, 9'b0,            32'h0,  32'h0,  32'h0);
        vecs[6]  = mk(0, 1, 1, 1, 1, 1, 0, 0, 32'h0,  9'b0,            32'h0,  32'h0,  32'h0);
        vecs[7]  = mk(0, 1, 1, 1, 1, 1, 1, 1, 32'h77, 9'b111_01_0011,  32'h0,  32'h77, DA);
        vecs[8]  = mk(0, 1, 1, 1, 1, 1, 0, 0, 32'h0,  9'b0,            32'h0,  32'h0,  32'h0);
        vecs[9]  = mk(0, 1, 1, 1, 1, 1, 1, 1, 32'h88, 9'b110_10_1100,  32'h88, 32'h0,  IA);
        vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,  9'b0,            32'h0,  32'h0,  32'h0);

        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            reset = vecs[k].rst; i_req = vecs[k].ireq; i_single = vecs[k].isingle;
            d_req = vecs[k].dreq; d_single = vecs[k].dsingle; d_wr = vecs[k].dwr;
            mem_addr_ok = vecs[k].aok; mem_data_ok = vecs[k].dok; mem_rdata = vecs[k].rdata;
            #1;
            chk($sformatf("vec%0d flags", k),
                {busy, mem_req, mem_wr, mem_size, i_addr_ok, i_data_ok, d_addr_ok, d_data_ok},
                vecs[k].flags);
            chk($sformatf("vec%0d i_rdata", k), i_rdata, vecs[k].irdata);
            chk($sformatf("vec%0d d_rdata", k), d_rdata, vecs[k].drdata);
            chk($sformatf("vec%0d mem_addr", k), mem_addr, vecs[k].maddr);
        end

        // dCache write-back burst with addr_ok held high well past the 8th accept
        do_reset();
        d_req = 1; d_single = 0; d_wr = 1;
        acc = 0; dcnt = 0; ibad = 0; wrbad = 0; reqbad = 0; rdbad = 0; wdbad = 0;
        c8 = -10; busy_next = -1;
        for (int c = 0; c < 40; c++) begin
            model_cycle();
            if (acc >= 8 && mem_req) reqbad++;
            if (mem_req && mem_addr_ok) acc++;
            if (d_data_ok) begin
                dcnt++;
                if (d_rdata !== mem_rdata) rdbad++;
                if (dcnt == 8) begin
                    c8 = c;
                    d_req = 0;
                end
            end
            if (i_data_ok) ibad++;
            if (busy && !mem_wr) wrbad++;
            if (busy && mem_wdata !== DW) wdbad++;
            if (c == c8 + 1) busy_next = int'(busy);
        end
        chk("burst addr accepts", acc, 8);
        chk("burst d_data_ok", dcnt, 8);
        chk("burst i_data_ok", ibad, 0);
        chk("burst mem_wr", wrbad, 0);
        chk("burst mem_wdata", wdbad, 0);
        chk("burst mem_req after 8", reqbad, 0);
        chk("burst d_rdata", rdbad, 0);
        chk("burst busy after last", busy_next, 0);

        // both masters requesting: D first, then alternate with one idle cycle between
        do_reset();
        i_req = 1; i_single = 0; d_req = 1; d_single = 0; d_wr = 0;
        ng = 0; gapbad = 0; idle = 0; gseq = 0; prev_busy = 0;
        for (int c = 0; c < 200 && ng < 4; c++) begin
            model_cycle();
            if (!busy) idle++;
            if (busy && !prev_busy) begin
                gseq[3-ng] = (mem_addr == DA);
                if (ng > 0 && idle != 1) gapbad++;
                ng++;
                idle = 0;
            end
            prev_busy = busy;
        end
        chk("rr grant count", ng, 4);
        chk("rr grant order", gseq, 4'b1010);
        chk("rr idle gap", gapbad, 0);

        // reset after the 3rd data beat of a D burst, then a fresh iCache burst
        do_reset();
        d_req = 1; d_single = 0; d_wr = 1; dcnt = 0;
        for (int c = 0; c < 30 && dcnt < 3; c++) begin
            model_cycle();
            if (d_data_ok) dcnt++;
        end
        chk("rst mid d beats", dcnt, 3);
        @(negedge clk);
        reset = 1; mem_addr_ok = 1; mem_data_ok = 1;
        @(negedge clk);
        #1;
        chk("rst mid outputs",
            {busy, mem_req, i_addr_ok, i_data_ok, d_addr_ok, d_data_ok}, 6'b0);
        reset = 0; d_req = 0; i_req = 1; i_single = 0; pipe = 0;
        mem_addr_ok = 0; mem_data_ok = 0;
        icnt = 0; acc = 0; prev_busy = 0; idle = 0;
        for (int c = 0; c < 40; c++) begin
            model_cycle();
            if (mem_req && mem_addr_ok) acc++;
            if (i_data_ok) icnt++;
            if (prev_busy && !busy) begin
                idle = 1;
                break;
            end
            prev_busy = busy;
            if (icnt == 8) i_req = 0;
        end
        chk("post rst i accepts", acc, 8);
        chk("post rst i beats", icnt, 8);
        chk("post rst release", idle, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
